// File: rtl/lsu_mem_access.sv
// Load/store access unit for the MEM stage.
// Turns one load or store into a word-aligned data-bus transaction with byte
// enables and a req/ack handshake, extends load data, and stalls the pipeline
// while the transaction is outstanding.
//
// Ports:
//   i_clk, i_rst             clock, synchronous active-high reset
//   i_valid                  MEM-stage instruction valid (held while o_stall)
//   i_MemRead, i_MemWrite    load / store request
//   i_Mem_Mode               funct3 access size / signedness
//   i_Addr, i_StoreData      effective byte address, rs2 value
//   o_stall                  freeze upstream pipeline (combinational)
//   o_done                   one-cycle completion pulse
//   o_LoadData               extended load result, valid with o_done
//   o_misalign, o_fault      completion status, valid with o_done
//   o_bus_*                  registered data-bus request fields
//   i_bus_ack, i_bus_rdata   bus completion and read word
module lsu_mem_access #(
  parameter int unsigned WAIT_MAX = 255
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  input  logic        i_MemRead,
  input  logic        i_MemWrite,
  input  logic [2:0]  i_Mem_Mode,
  input  logic [31:0] i_Addr,
  input  logic [31:0] i_StoreData,
  output logic        o_stall,
  output logic        o_done,
  output logic [31:0] o_LoadData,
  output logic        o_misalign,
  output logic        o_fault,
  output logic        o_bus_req,
  output logic        o_bus_we,
  output logic [31:0] o_bus_addr,
  output logic [31:0] o_bus_wdata,
  output logic [3:0]  o_bus_be,
  input  logic        i_bus_ack,
  input  logic [31:0] i_bus_rdata
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(WAIT_MAX - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       mode_q, mode_d;
  logic [1:0]       addr_lo_q, addr_lo_d;
  logic             req_q, req_d;
  logic             we_q, we_d;
  logic [31:0]      baddr_q, baddr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [3:0]       be_q, be_d;
  logic             done_q, done_d;
  logic [31:0]      load_q, load_d;
  logic             mis_q, mis_d;
  logic             flt_q, flt_d;

  logic             start_c;
  logic             illegal_c;
  logic             misalign_c;
  logic [3:0]       be_c;
  logic [31:0]      wdata_c;
  logic [7:0]       byte_c;
  logic [15:0]      half_c;
  logic [31:0]      ext_c;

  assign start_c = i_valid & (i_MemRead | i_MemWrite);
  assign o_stall = ((state_q == IDLE) & start_c) | (state_q == BUSY);

  // Legality of the requested access; illegal outranks misalign.
  always_comb begin
    illegal_c = 1'b0;
    if (i_MemRead & i_MemWrite) begin
      illegal_c = 1'b1;
    end else if (i_MemRead) begin
      case (i_Mem_Mode)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: illegal_c = 1'b0;
        default:                                illegal_c = 1'b1;
      endcase
    end else begin
      illegal_c = (i_Mem_Mode != 3'b000) & (i_Mem_Mode != 3'b001) &
                  (i_Mem_Mode != 3'b010);
    end
  end

  // Low two mode bits encode size for both signed and unsigned loads.
  assign misalign_c = ((i_Mem_Mode[1:0] == 2'b01) & i_Addr[0]) |
                      ((i_Mem_Mode[1:0] == 2'b10) & (i_Addr[1:0] != 2'b00));

  // Byte enables and replicated store data for the incoming access.
  always_comb begin
    be_c    = 4'b1111;
    wdata_c = i_StoreData;
    case (i_Mem_Mode[1:0])
      2'b00: begin
        be_c    = 4'b0001 << i_Addr[1:0];
        wdata_c = {4{i_StoreData[7:0]}};
      end
      2'b01: begin
        be_c    = i_Addr[1] ? 4'b1100 : 4'b0011;
        wdata_c = {2{i_StoreData[15:0]}};
      end
      default: begin
        be_c    = 4'b1111;
        wdata_c = i_StoreData;
      end
    endcase
  end

  // Lane select and extension of the returned word using the latched access.
  always_comb begin
    case (addr_lo_q)
      2'b00:   byte_c = i_bus_rdata[7:0];
      2'b01:   byte_c = i_bus_rdata[15:8];
      2'b10:   byte_c = i_bus_rdata[23:16];
      default: byte_c = i_bus_rdata[31:24];
    endcase
    half_c = addr_lo_q[1] ? i_bus_rdata[31:16] : i_bus_rdata[15:0];
    case (mode_q)
      3'b000:  ext_c = {{24{byte_c[7]}}, byte_c};
      3'b001:  ext_c = {{16{half_c[15]}}, half_c};
      3'b010:  ext_c = i_bus_rdata;
      3'b100:  ext_c = {24'd0, byte_c};
      3'b101:  ext_c = {16'd0, half_c};
      default: ext_c = 32'd0;
    endcase
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mode_d    = mode_q;
    addr_lo_d = addr_lo_q;
    we_d      = we_q;
    baddr_d   = baddr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    req_d     = 1'b0;
    done_d    = 1'b0;
    load_d    = 32'd0;
    mis_d     = 1'b0;
    flt_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_c) begin
          if (illegal_c) begin
            state_d = DONE;
            done_d  = 1'b1;
            flt_d   = 1'b1;
          end else if (misalign_c) begin
            state_d = DONE;
            done_d  = 1'b1;
            mis_d   = 1'b1;
          end else begin
            state_d   = BUSY;
            req_d     = 1'b1;
            cnt_d     = '0;
            mode_d    = i_Mem_Mode;
            addr_lo_d = i_Addr[1:0];
            we_d      = i_MemWrite;
            baddr_d   = {i_Addr[31:2], 2'b00};
            wdata_d   = wdata_c;
            be_d      = be_c;
          end
        end
      end
      BUSY: begin
        if (i_bus_ack) begin
          state_d = DONE;
          done_d  = 1'b1;
          load_d  = we_q ? 32'd0 : ext_c;
        end else if (cnt_q == WAIT_LAST) begin
          state_d = DONE;
          done_d  = 1'b1;
          flt_d   = 1'b1;
        end else begin
          req_d = 1'b1;
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      mode_q    <= 3'd0;
      addr_lo_q <= 2'd0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      baddr_q   <= 32'd0;
      wdata_q   <= 32'd0;
      be_q      <= 4'd0;
      done_q    <= 1'b0;
      load_q    <= 32'd0;
      mis_q     <= 1'b0;
      flt_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mode_q    <= mode_d;
      addr_lo_q <= addr_lo_d;
      req_q     <= req_d;
      we_q      <= we_d;
      baddr_q   <= baddr_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      done_q    <= done_d;
      load_q    <= load_d;
      mis_q     <= mis_d;
      flt_q     <= flt_d;
    end
  end

  assign o_done      = done_q;
  assign o_LoadData  = load_q;
  assign o_misalign  = mis_q;
  assign o_fault     = flt_q;
  assign o_bus_req   = req_q;
  assign o_bus_we    = we_q;
  assign o_bus_addr  = baddr_q;
  assign o_bus_wdata = wdata_q;
  assign o_bus_be    = be_q;

endmodule

// File: tb/tb_lsu_mem_access.sv
// Directed bench for lsu_mem_access: expected completions are queued when an
// access is issued and popped when o_done is observed.
module tb_lsu_mem_access;

  localparam int unsigned WAIT_MAX = 4;

  logic        i_clk;
  logic        i_rst;
  logic        i_valid;
  logic        i_MemRead;
  logic        i_MemWrite;
  logic [2:0]  i_Mem_Mode;
  logic [31:0] i_Addr;
  logic [31:0] i_StoreData;
  logic        o_stall;
  logic        o_done;
  logic [31:0] o_LoadData;
  logic        o_misalign;
  logic        o_fault;
  logic        o_bus_req;
  logic        o_bus_we;
  logic [31:0] o_bus_addr;
  logic [31:0] o_bus_wdata;
  logic [3:0]  o_bus_be;
  logic        i_bus_ack;
  logic [31:0] i_bus_rdata;

  lsu_mem_access #(.WAIT_MAX(WAIT_MAX)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_valid     (i_valid),
    .i_MemRead   (i_MemRead),
    .i_MemWrite  (i_MemWrite),
    .i_Mem_Mode  (i_Mem_Mode),
    .i_Addr      (i_Addr),
    .i_StoreData (i_StoreData),
    .o_stall     (o_stall),
    .o_done      (o_done),
    .o_LoadData  (o_LoadData),
    .o_misalign  (o_misalign),
    .o_fault     (o_fault),
    .o_bus_req   (o_bus_req),
    .o_bus_we    (o_bus_we),
    .o_bus_addr  (o_bus_addr),
    .o_bus_wdata (o_bus_wdata),
    .o_bus_be    (o_bus_be),
    .i_bus_ack   (i_bus_ack),
    .i_bus_rdata (i_bus_rdata)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [31:0] data;
    logic        mis;
    logic        flt;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    @(negedge i_clk);
  endtask

  task automatic check_done(input string tag);
    exp_t e;
    chk({tag, ".done"}, 32'(o_done), 32'd1);
    chk({tag, ".sb_depth"}, 32'(sb_q.size()), 32'd1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk({tag, ".load_data"}, o_LoadData, e.data);
      chk({tag, ".misalign"}, 32'(o_misalign), 32'(e.mis));
      chk({tag, ".fault"}, 32'(o_fault), 32'(e.flt));
    end
  endtask

  task automatic drive_idle();
    i_valid     = 1'b0;
    i_MemRead   = 1'b0;
    i_MemWrite  = 1'b0;
    i_Mem_Mode  = 3'd0;
    i_Addr      = 32'd0;
    i_StoreData = 32'd0;
  endtask

  // Issue one access at a negedge (cycle T) and follow it to completion.
  task automatic run_op(input string tag, input logic rd, input logic wr,
                        input logic [2:0] mode, input logic [31:0] addr,
                        input logic [31:0] sd, input int wait_n,
                        input logic [31:0] rdata, input logic bus,
                        input logic [3:0] be, input logic [31:0] wdata,
                        input logic [31:0] data, input logic mis, input logic flt);
    exp_t e;
    i_valid     = 1'b1;
    i_MemRead   = rd;
    i_MemWrite  = wr;
    i_Mem_Mode  = mode;
    i_Addr      = addr;
    i_StoreData = sd;
    e.data = data;
    e.mis  = mis;
    e.flt  = flt;
    sb_q.push_back(e);
    #1 chk({tag, ".stall_T"}, 32'(o_stall), 32'd1);
    step();
    if (bus) begin
      chk({tag, ".req"}, 32'(o_bus_req), 32'd1);
      chk({tag, ".stall_busy"}, 32'(o_stall), 32'd1);
      chk({tag, ".bus_addr"}, o_bus_addr, {addr[31:2], 2'b00});
      chk({tag, ".bus_be"}, 32'(o_bus_be), 32'(be));
      chk({tag, ".bus_we"}, 32'(o_bus_we), 32'(wr));
      if (wr) chk({tag, ".bus_wdata"}, o_bus_wdata, wdata);
      for (int k = 0; k < wait_n; k++) begin
        step();
        chk({tag, ".req_wait"}, 32'(o_bus_req), 32'd1);
        chk({tag, ".addr_wait"}, o_bus_addr, {addr[31:2], 2'b00});
      end
      i_bus_ack   = 1'b1;
      i_bus_rdata = rdata;
      step();
      i_bus_ack   = 1'b0;
      i_bus_rdata = 32'd0;
    end
    chk({tag, ".req_done"}, 32'(o_bus_req), 32'd0);
    chk({tag, ".stall_done"}, 32'(o_stall), 32'd0);
    check_done(tag);
    drive_idle();
    step();
    chk({tag, ".done_clr"}, 32'({o_done, o_misalign, o_fault}), 32'd0);
  endtask

  initial begin
    i_rst       = 1'b1;
    i_bus_ack   = 1'b0;
    i_bus_rdata = 32'd0;
    drive_idle();
    @(negedge i_clk);
    step();
    step();
    chk("reset.outs", 32'({o_done, o_misalign, o_fault, o_bus_req, o_bus_we, o_stall}), 32'd0);
    chk("reset.data", o_LoadData | o_bus_addr | o_bus_wdata, 32'd0);
    chk("reset.be", 32'(o_bus_be), 32'd0);
    i_rst = 1'b0;
    step();

    // Loads with lane selection and extension.
    run_op("lw",      1, 0, 3'b010, 32'h100, 32'd0, 0, 32'hDEADBEEF, 1, 4'b1111, 32'd0, 32'hDEADBEEF, 0, 0);
    run_op("lb",      1, 0, 3'b000, 32'h103, 32'd0, 0, 32'h80112233, 1, 4'b1000, 32'd0, 32'hFFFFFF80, 0, 0);
    run_op("lbu",     1, 0, 3'b100, 32'h103, 32'd0, 0, 32'h80112233, 1, 4'b1000, 32'd0, 32'h00000080, 0, 0);
    run_op("lhu",     1, 0, 3'b101, 32'h102, 32'd0, 0, 32'h80112233, 1, 4'b1100, 32'd0, 32'h00008011, 0, 0);
    run_op("lh_wait", 1, 0, 3'b001, 32'h102, 32'd0, 2, 32'h80112233, 1, 4'b1100, 32'd0, 32'hFFFF8011, 0, 0);
    run_op("lb0",     1, 0, 3'b000, 32'h0F0, 32'd0, 1, 32'h0000007F, 1, 4'b0001, 32'd0, 32'h0000007F, 0, 0);
    run_op("lw_last", 1, 0, 3'b010, 32'h104, 32'd0, 3, 32'h13579BDF, 1, 4'b1111, 32'd0, 32'h13579BDF, 0, 0);

    // Stores: replicated data, load result stays zero.
    run_op("sb", 0, 1, 3'b000, 32'h201, 32'h000000A5, 1, 32'hFFFFFFFF, 1, 4'b0010, 32'hA5A5A5A5, 32'd0, 0, 0);
    run_op("sh", 0, 1, 3'b001, 32'h202, 32'hABCD1234, 0, 32'hFFFFFFFF, 1, 4'b1100, 32'h12341234, 32'd0, 0, 0);
    run_op("sw", 0, 1, 3'b010, 32'h204, 32'hCAFEF00D, 0, 32'hFFFFFFFF, 1, 4'b1111, 32'hCAFEF00D, 32'd0, 0, 0);

    // Misaligned and illegal accesses never reach the bus.
    run_op("lw_mis",   1, 0, 3'b010, 32'h102, 32'd0, 0, 32'd0, 0, 4'd0, 32'd0, 32'd0, 1, 0);
    run_op("lh_mis",   1, 0, 3'b001, 32'h101, 32'd0, 0, 32'd0, 0, 4'd0, 32'd0, 32'd0, 1, 0);
    run_op("sb_mode4", 0, 1, 3'b100, 32'h200, 32'h11, 0, 32'd0, 0, 4'd0, 32'd0, 32'd0, 0, 1);
    run_op("ld_mode3", 1, 0, 3'b011, 32'h101, 32'd0, 0, 32'd0, 0, 4'd0, 32'd0, 32'd0, 0, 1);
    run_op("ld_mode6", 1, 0, 3'b110, 32'h100, 32'd0, 0, 32'd0, 0, 4'd0, 32'd0, 32'd0, 0, 1);
    run_op("rd_wr",    1, 1, 3'b010, 32'h500, 32'd0, 0, 32'd0, 0, 4'd0, 32'd0, 32'd0, 0, 1);

    // Ack while idle is ignored.
    i_bus_ack = 1'b1;
    step();
    chk("idle_ack", 32'({o_bus_req, o_done, o_stall}), 32'd0);
    i_bus_ack = 1'b0;

    // Timeout: req for WAIT_MAX cycles, then fault; a late ack is ignored.
    i_valid    = 1'b1;
    i_MemRead  = 1'b1;
    i_Mem_Mode = 3'b010;
    i_Addr     = 32'h300;
    sb_q.push_back('{data: 32'd0, mis: 1'b0, flt: 1'b1});
    #1 chk("tmo.stall_T", 32'(o_stall), 32'd1);
    for (int k = 0; k < int'(WAIT_MAX); k++) begin
      step();
      chk("tmo.req", 32'(o_bus_req), 32'd1);
    end
    step();
    chk("tmo.req_drop", 32'(o_bus_req), 32'd0);
    check_done("tmo");
    drive_idle();
    i_bus_ack   = 1'b1;
    i_bus_rdata = 32'hFFFFFFFF;
    step();
    chk("tmo.late_ack", 32'({o_done, o_bus_req, o_stall, o_fault}), 32'd0);
    i_bus_ack   = 1'b0;
    i_bus_rdata = 32'd0;
    step();
    chk("tmo.quiet", 32'(o_done), 32'd0);

    // Reset in the third BUSY cycle aborts without a completion.
    i_valid    = 1'b1;
    i_MemRead  = 1'b1;
    i_Mem_Mode = 3'b010;
    i_Addr     = 32'h400;
    step();
    step();
    step();
    chk("rst_busy.req", 32'(o_bus_req), 32'd1);
    i_rst = 1'b1;
    drive_idle();
    step();
    chk("rst_busy.after", 32'({o_bus_req, o_stall, o_done, o_fault, o_misalign}), 32'd0);
    chk("rst_busy.addr", o_bus_addr, 32'd0);
    i_rst = 1'b0;
    step();
    run_op("lw_after_rst", 1, 0, 3'b010, 32'h404, 32'd0, 0, 32'h0BADF00D, 1, 4'b1111, 32'd0, 32'h0BADF00D, 0, 0);

    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
